divide_unit: RTL and testbench

Sequential 32-bit integer divider for the ALU: the inverse of the combinational multiplier. It produces quotient and remainder with the same HI/LO split (remainder in HI, quotient in LO, MIPS `div`/`divu` style) and the same signed/unsigned selection through `sign[1]`. It computes one restoring-division bit per clock. The ALU control starts it with a one-cycle `start` and collects results on `done`.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/divide_unit_if.sv | 28 ++
 rtl/div_step.sv | 28 ++
 rtl/divide_unit.sv | 112 +++++++++++
 tb/tb_divide_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, divider state encoding and a
// two's-complement magnitude helper used when latching operands.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } div_state_t;

    // Magnitude of v when interpreted as signed; raw value otherwise.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/divide_unit_if.sv
// Request/result bundle between the ALU control (master) and the divider (slave).
interface divide_unit_if;
    import alu_pkg::*;

    // start is a single-cycle request, honoured only while busy is low; the
    // operands are captured on that edge only. done is a one-cycle pulse and
    // quotientLO/remainderHI/divByZero stay valid until the next result.
    logic             start;
    logic [1:0]       sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotientLO;
    logic [WIDTH-1:0] remainderHI;
    logic             busy;
    logic             done;
    logic             divByZero;

    modport master (
        output start, sign, dividend, divisor,
        input  quotientLO, remainderHI, busy, done, divByZero
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output quotientLO, remainderHI, busy, done, divByZero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left and try to subtract
// the divisor from the widened partial remainder.
module div_step
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             unused_trial_msb;

    assign rem_sh    = {rem_i, quo_i[WIDTH-1]};
    assign no_borrow = (rem_sh >= {1'b0, divisor_i});
    assign trial     = rem_sh - {1'b0, divisor_i};

    // rem stays below the divisor, so an accepted trial always fits WIDTH bits.
    assign unused_trial_msb = trial[WIDTH];

    assign rem_o = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/divide_unit.sv
// Sequential restoring divider: one quotient bit per clock, sign handled by
// magnitude division plus a final negation step. Remainder in HI, quotient in LO.
module divide_unit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    divide_unit_if.slave bus,
    output div_state_t dbg_state_o
);

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             negq_q;
    logic             negr_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_out_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic             is_signed;
    logic             div_zero;
    logic             unused_sign0;

    assign is_signed    = bus.sign[1];
    assign div_zero     = (bus.divisor == '0);
    assign unused_sign0 = bus.sign[0];

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_out_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        dvs_q   <= mag(bus.divisor, is_signed);
                        negq_q  <= is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        negr_q  <= is_signed & bus.dividend[WIDTH-1];
                        dbz_q   <= div_zero;
                        // A zero divisor keeps the raw dividend for the HI result.
                        quo_q   <= div_zero ? bus.dividend : mag(bus.dividend, is_signed);
                        busy_q  <= 1'b1;
                        state_q <= div_zero ? FIXUP : DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (dbz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= quo_q;
                    end else begin
                        quotient_q  <= negq_q ? -quo_q : quo_q;
                        remainder_q <= negr_q ? -rem_q : rem_q;
                    end
                    dbz_out_q <= dbz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotientLO  = quotient_q;
    assign bus.remainderHI = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.divByZero   = dbz_out_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: directed cases plus randomized
// operands compared against a plain-arithmetic reference model.
module tb_divide_unit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    div_state_t dbg_state;

    always #5 clk = ~clk;

    divide_unit_if itf ();

    divide_unit dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (itf),
        .dbg_state_o (dbg_state)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: MIPS div/divu semantics from plain integer arithmetic.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic is_s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        itf.start    = 1'b1;
        itf.dividend = a;
        itf.divisor  = b;
        itf.sign     = s;
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (itf.done) cnt++;
        end
    endtask

    // Issues one operation and returns at the negedge where done is high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] s, input bit chained, input int inject_at,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz);
        logic [31:0] mq, mr;
        int          cyc, bcnt, exp_lat;
        bit          got_done;
        if (!chained) @(negedge clk);
        issue(a, b, s);
        ref_div(a, b, s[1], mq, mr);
        exp_q.push_back(mq);
        exp_q.push_back(mr);
        exp_q.push_back({31'd0, (b == 32'd0)});
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(posedge clk);
        #1;
        itf.start    = 1'b0;
        itf.dividend = $urandom;
        itf.divisor  = $urandom;
        itf.sign     = 2'($urandom);
        cyc      = 0;
        bcnt     = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (itf.done) got_done = 1'b1;
            else if (itf.busy) bcnt++;
            if (!got_done && cyc == inject_at) begin
                issue($urandom, $urandom_range(1, 9), 2'($urandom));
                @(posedge clk);
                #1 itf.start = 1'b0;
            end
        end
        chk({tag, " done seen"}, {31'd0, got_done}, 32'd1);
        chk({tag, " latency"}, cyc - 1, exp_lat);
        chk({tag, " busy cycles"}, bcnt, exp_lat);
        chk({tag, " busy at done"}, {31'd0, itf.busy}, 32'd0);
        q   = itf.quotientLO;
        r   = itf.remainderHI;
        dbz = itf.divByZero;
        chk({tag, " model q"}, q, exp_q.pop_front());
        chk({tag, " model r"}, r, exp_q.pop_front());
        chk({tag, " model dbz"}, {31'd0, dbz}, exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] q, r, a, b;
        logic        dbz;
        logic [1:0]  s;
        int          nd;

        reset        = 1'b1;
        itf.start    = 1'b0;
        itf.sign     = 2'b00;
        itf.dividend = '0;
        itf.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst q", itf.quotientLO, 32'd0);
        chk("rst r", itf.remainderHI, 32'd0);
        chk("rst busy", {31'd0, itf.busy}, 32'd0);
        chk("rst done", {31'd0, itf.done}, 32'd0);
        chk("rst dbz", {31'd0, itf.divByZero}, 32'd0);
        chk("rst state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;

        run_op("u100/7", 32'd100, 32'd7, 2'b00, 1'b0, 0, q, r, dbz);
        chk("u100/7 q", q, 32'd14);
        chk("u100/7 r", r, 32'd2);

        run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 2'b10, 1'b0, 0, q, r, dbz);
        chk("s-7/2 q", q, 32'hFFFF_FFFD);
        chk("s-7/2 r", r, 32'hFFFF_FFFF);

        run_op("u-7/2", 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0, 0, q, r, dbz);
        chk("u-7/2 q", q, 32'h7FFF_FFFC);
        chk("u-7/2 r", r, 32'd1);

        run_op("5/0", 32'd5, 32'd0, 2'b10, 1'b0, 0, q, r, dbz);
        chk("5/0 q", q, 32'hFFFF_FFFF);
        chk("5/0 r", r, 32'd5);
        chk("5/0 dbz", {31'd0, dbz}, 32'd1);
        repeat (4) @(negedge clk);
        chk("5/0 hold q", itf.quotientLO, 32'hFFFF_FFFF);
        chk("5/0 hold dbz", {31'd0, itf.divByZero}, 32'd1);

        run_op("9/3", 32'd9, 32'd3, 2'b00, 1'b0, 0, q, r, dbz);
        chk("9/3 q", q, 32'd3);
        chk("9/3 r", r, 32'd0);
        chk("9/3 dbz", {31'd0, dbz}, 32'd0);

        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0, 0, q, r, dbz);
        chk("ovf q", q, 32'h8000_0000);
        chk("ovf r", r, 32'd0);

        // Mid-flight start must be ignored; a start in the done cycle is taken.
        run_op("inject", 32'd100, 32'd7, 2'b00, 1'b0, 10, q, r, dbz);
        chk("inject q", q, 32'd14);
        chk("inject r", r, 32'd2);
        run_op("b2b", 32'd1234, 32'd11, 2'b00, 1'b1, 0, q, r, dbz);
        chk("b2b q", q, 32'd112);
        chk("b2b r", r, 32'd2);
        count_dones(40, nd);
        chk("no extra done", nd, 0);

        @(negedge clk);
        issue(32'd12345, 32'd7, 2'b00);
        @(posedge clk);
        #1 itf.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst busy", {31'd0, itf.busy}, 32'd0);
        chk("mid rst q", itf.quotientLO, 32'd0);
        chk("mid rst r", itf.remainderHI, 32'd0);
        chk("mid rst done", {31'd0, itf.done}, 32'd0);
        reset = 1'b0;
        count_dones(40, nd);
        chk("rst no done", nd, 0);
        run_op("1000/10", 32'd1000, 32'd10, 2'b00, 1'b0, 0, q, r, dbz);
        chk("1000/10 q", q, 32'd100);
        chk("1000/10 r", r, 32'd0);

        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            s = 2'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:       begin a = $urandom_range(0, 50); b = $urandom_range(1, 60); end
                default: b = $urandom;
            endcase
            run_op("rand", a, b, s, 1'b0, 0, q, r, dbz);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
